// File: rtl/add_rs_scheduler_pkg.sv
// Shared types and constants for the add/sub reservation-station scheduler.
// Optional feature macro used by this block: ADD_RS_ROUND_ROBIN_EN.
package add_rs_scheduler_pkg;

    localparam int NUM_RS      = 3;
    localparam int TAG_W       = 2;
    localparam int DATA_W      = 16;
    localparam int ADD_LATENCY = 2;

    localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int CNT_W = $clog2(ADD_LATENCY + 1);

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [TAG_W-1:0] NULL_TAG = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    typedef struct packed {
        logic              busy;
        logic              op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
    } rs_entry_t;

    // Entry i owns tag i+1 so that tag 0 stays free to mean "no producer".
    function automatic logic [TAG_W-1:0] idx_to_tag(input logic [IDX_W-1:0] idx);
        return TAG_W'(idx) + TAG_W'(1);
    endfunction

endpackage

// File: rtl/add_rs_scheduler_if.sv
// Issue, CDB and adder-unit signal bundle around the add/sub scheduler.
interface add_rs_scheduler_if;
    import add_rs_scheduler_pkg::*;

    logic              issue_valid;
    logic              issue_op;
    logic [DATA_W-1:0] issue_vj;
    logic [DATA_W-1:0] issue_vk;
    logic [TAG_W-1:0]  issue_qj;
    logic [TAG_W-1:0]  issue_qk;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_tag;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              fu_op;
    logic [DATA_W-1:0] fu_a;
    logic [DATA_W-1:0] fu_b;
    logic [DATA_W-1:0] fu_result;

    logic              cdb_req;
    logic [TAG_W-1:0]  cdb_req_tag;
    logic [DATA_W-1:0] cdb_req_data;
    logic              cdb_grant;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        input  issue_ready, issue_tag,
        output cdb_valid, cdb_tag, cdb_data,
        input  fu_op, fu_a, fu_b,
        output fu_result,
        input  cdb_req, cdb_req_tag, cdb_req_data,
        output cdb_grant
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        output issue_ready, issue_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        output fu_op, fu_a, fu_b,
        input  fu_result,
        output cdb_req, cdb_req_tag, cdb_req_data,
        input  cdb_grant
    );
endinterface

// File: rtl/add_rs_scheduler_rs_select.sv
// Picks one ready reservation-station entry: lowest index by default,
// rotating priority after the last dispatched index under ADD_RS_ROUND_ROBIN_EN.
module rs_select
    import add_rs_scheduler_pkg::*;
(
    input  logic [NUM_RS-1:0] ready_i,
`ifdef ADD_RS_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0]  last_idx_i,
`endif
    output logic              any_o,
    output logic [IDX_W-1:0]  idx_o
);

`ifdef ADD_RS_ROUND_ROBIN_EN
    // Scan from farthest to nearest so the first ready entry after last_idx_i wins.
    always_comb begin
        int cand;
        cand  = 0;
        any_o = 1'b0;
        idx_o = '0;
        for (int k = NUM_RS; k >= 1; k--) begin
            cand = (int'(last_idx_i) + k) % NUM_RS;
            if (ready_i[cand]) begin
                any_o = 1'b1;
                idx_o = IDX_W'(cand);
            end
        end
    end
`else
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (ready_i[i]) begin
                any_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/add_rs_scheduler.sv
// Reservation-station scheduler for the shared add/sub unit: issue, CDB wakeup,
// one-at-a-time dispatch, fixed-latency execute and CDB write-back.
module add_rs_scheduler
    import add_rs_scheduler_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    add_rs_scheduler_if.slave  bus
);

    rs_entry_t         entries_q [NUM_RS];
    rs_entry_t         entries_d [NUM_RS];
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              fu_op_q, fu_op_d;
    logic [DATA_W-1:0] fu_a_q, fu_a_d;
    logic [DATA_W-1:0] fu_b_q, fu_b_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic [NUM_RS-1:0] ready_vec;
    logic [NUM_RS-1:0] wake_j;
    logic [NUM_RS-1:0] wake_k;
    logic              any_free;
    logic [IDX_W-1:0]  free_idx;
    logic              sel_any;
    logic [IDX_W-1:0]  sel_idx;
    logic              issue_fire;
    logic              grant_fire;
    logic              cdb_live;

    assign cdb_live = bus.cdb_valid && (bus.cdb_tag != NULL_TAG);

    for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_entry
        assign ready_vec[gi] = entries_q[gi].busy
                            && (entries_q[gi].qj == NULL_TAG)
                            && (entries_q[gi].qk == NULL_TAG);
        assign wake_j[gi] = entries_q[gi].busy && cdb_live && (entries_q[gi].qj == bus.cdb_tag);
        assign wake_k[gi] = entries_q[gi].busy && cdb_live && (entries_q[gi].qk == bus.cdb_tag);
    end

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!entries_q[i].busy) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    rs_select u_select (
        .ready_i    (ready_vec),
`ifdef ADD_RS_ROUND_ROBIN_EN
        .last_idx_i (idx_q),
`endif
        .any_o      (sel_any),
        .idx_o      (sel_idx)
    );

    assign issue_fire = bus.issue_valid && any_free;
    assign grant_fire = (state_q == ST_WB) && bus.cdb_grant;

    // Issue only ever targets a free entry and wakeup/free only touch busy ones,
    // so the three updates below never collide on the same entry.
    always_comb begin
        for (int i = 0; i < NUM_RS; i++) begin
            entries_d[i] = entries_q[i];
            if (wake_j[i]) begin
                entries_d[i].vj = bus.cdb_data;
                entries_d[i].qj = NULL_TAG;
            end
            if (wake_k[i]) begin
                entries_d[i].vk = bus.cdb_data;
                entries_d[i].qk = NULL_TAG;
            end
            if (grant_fire && (idx_q == IDX_W'(i))) begin
                entries_d[i].busy = 1'b0;
            end
        end
        if (issue_fire) begin
            entries_d[free_idx].busy = 1'b1;
            entries_d[free_idx].op   = bus.issue_op;
            entries_d[free_idx].vj   = bus.issue_vj;
            entries_d[free_idx].vk   = bus.issue_vk;
            entries_d[free_idx].qj   = bus.issue_qj;
            entries_d[free_idx].qk   = bus.issue_qk;
            if (cdb_live && (bus.issue_qj == bus.cdb_tag)) begin
                entries_d[free_idx].vj = bus.cdb_data;
                entries_d[free_idx].qj = NULL_TAG;
            end
            if (cdb_live && (bus.issue_qk == bus.cdb_tag)) begin
                entries_d[free_idx].vk = bus.cdb_data;
                entries_d[free_idx].qk = NULL_TAG;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        fu_op_d  = fu_op_q;
        fu_a_d   = fu_a_q;
        fu_b_d   = fu_b_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    state_d = ST_EXEC;
                    idx_d   = sel_idx;
                    cnt_d   = '0;
                    fu_op_d = entries_q[sel_idx].op;
                    fu_a_d  = entries_q[sel_idx].vj;
                    fu_b_d  = entries_q[sel_idx].vk;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ADD_LATENCY - 1)) begin
                    result_d = bus.fu_result;
                    state_d  = ST_WB;
                end
            end
            ST_WB: begin
                if (bus.cdb_grant) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            entries_q <= '{default: '0};
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            fu_op_q   <= 1'b0;
            fu_a_q    <= '0;
            fu_b_q    <= '0;
            result_q  <= '0;
        end else begin
            entries_q <= entries_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            fu_op_q   <= fu_op_d;
            fu_a_q    <= fu_a_d;
            fu_b_q    <= fu_b_d;
            result_q  <= result_d;
        end
    end

    assign bus.issue_ready  = any_free;
    assign bus.issue_tag    = any_free ? idx_to_tag(free_idx) : NULL_TAG;
    assign bus.fu_op        = fu_op_q;
    assign bus.fu_a         = fu_a_q;
    assign bus.fu_b         = fu_b_q;
    assign bus.cdb_req      = (state_q == ST_WB);
    assign bus.cdb_req_tag  = (state_q == ST_WB) ? idx_to_tag(idx_q) : NULL_TAG;
    assign bus.cdb_req_data = (state_q == ST_WB) ? result_q : '0;

endmodule

// File: tb/tb_add_rs_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a transaction-level reference model of the scheduler.
module tb_add_rs_scheduler;
    import add_rs_scheduler_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    add_rs_scheduler_if bus();

    add_rs_scheduler dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    // External adder: purely combinational on the held operands.
    assign bus.fu_result = bus.fu_op ? (bus.fu_a - bus.fu_b) : (bus.fu_a + bus.fu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: entry contents plus "which entry is in the unit and
    // from which cycle its result should be on offer".
    bit          m_busy [NUM_RS];
    bit          m_op   [NUM_RS];
    logic [15:0] m_a    [NUM_RS];
    logic [15:0] m_b    [NUM_RS];
    int          m_qj   [NUM_RS];
    int          m_qk   [NUM_RS];
    int          m_fly;
    int          m_req_cyc;
    int          m_last;
    int          cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_RS; i++) begin
            m_busy[i] = 0; m_op[i] = 0; m_a[i] = '0; m_b[i] = '0; m_qj[i] = 0; m_qk[i] = 0;
        end
        m_fly = -1; m_req_cyc = 0; m_last = 0; cyc = 0;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < NUM_RS; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NUM_RS; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic bit m_ready(input int i);
        return m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0;
    endfunction

    function automatic bit m_req();
        return m_fly >= 0 && cyc >= m_req_cyc;
    endfunction

    function automatic logic [15:0] m_result(input int i);
        return m_op[i] ? 16'(m_a[i] - m_b[i]) : 16'(m_a[i] + m_b[i]);
    endfunction

    function automatic int m_pick();
`ifdef ADD_RS_ROUND_ROBIN_EN
        for (int k = 1; k <= NUM_RS; k++) if (m_ready((m_last + k) % NUM_RS)) return (m_last + k) % NUM_RS;
`else
        for (int i = 0; i < NUM_RS; i++) if (m_ready(i)) return i;
`endif
        return -1;
    endfunction

    task automatic check_outputs();
        int f;
        f = m_free();
        check_eq("issue_ready", 32'(bus.issue_ready), 32'(f >= 0));
        if (f >= 0) check_eq("issue_tag", 32'(bus.issue_tag), 32'(f + 1));
        check_eq("cdb_req", 32'(bus.cdb_req), 32'(m_req()));
        if (m_req()) begin
            check_eq("cdb_req_tag", 32'(bus.cdb_req_tag), 32'(m_fly + 1));
            check_eq("cdb_req_data", 32'(bus.cdb_req_data), 32'(m_result(m_fly)));
        end
        if (m_fly >= 0) begin
            check_eq("fu_op", 32'(bus.fu_op), 32'(m_op[m_fly]));
            check_eq("fu_a", 32'(bus.fu_a), 32'(m_a[m_fly]));
            check_eq("fu_b", 32'(bus.fu_b), 32'(m_b[m_fly]));
        end
    endtask

    // Model of one clock edge; all decisions use the state before the edge.
    function automatic void model_edge(input bit iv, input bit op, input logic [15:0] vj, vk,
                                       input int qj, qk, input bit cv, input int ct,
                                       input logic [15:0] cd, input bit gr);
        int  f, pick;
        bit  granted;
        bit  was_busy [NUM_RS];
        f       = m_free();
        pick    = (m_fly < 0) ? m_pick() : -1;
        granted = m_req() && gr;
        for (int i = 0; i < NUM_RS; i++) was_busy[i] = m_busy[i];
        cyc++;
        if (granted) begin
            m_busy[m_fly] = 0;
            m_fly = -1;
        end
        if (pick >= 0) begin
            m_fly = pick; m_last = pick; m_req_cyc = cyc + ADD_LATENCY;
        end
        if (cv && ct != 0) begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (was_busy[i] && m_qj[i] == ct) begin m_a[i] = cd; m_qj[i] = 0; end
                if (was_busy[i] && m_qk[i] == ct) begin m_b[i] = cd; m_qk[i] = 0; end
            end
        end
        if (iv && f >= 0) begin
            m_busy[f] = 1; m_op[f] = op;
            m_a[f] = vj; m_qj[f] = qj;
            m_b[f] = vk; m_qk[f] = qk;
            if (cv && ct != 0 && qj == ct) begin m_a[f] = cd; m_qj[f] = 0; end
            if (cv && ct != 0 && qk == ct) begin m_b[f] = cd; m_qk[f] = 0; end
        end
    endfunction

    // Called at a falling edge: check, drive, let one rising edge pass, update model.
    task automatic step(input bit iv, input bit op, input logic [15:0] vj, vk,
                        input int qj, qk, input bit cv, input int ct,
                        input logic [15:0] cd, input bit gr);
        check_outputs();
        bus.issue_valid = iv;  bus.issue_op = op;
        bus.issue_vj = vj;     bus.issue_vk = vk;
        bus.issue_qj = 2'(qj); bus.issue_qk = 2'(qk);
        bus.cdb_valid = cv;    bus.cdb_tag = 2'(ct); bus.cdb_data = cd;
        bus.cdb_grant = gr;
        @(posedge clk);
        model_edge(iv, op, vj, vk, qj, qk, cv, ct, cd, gr);
        @(negedge clk);
        $display("cyc %0d: iv=%0b op=%0b vj=%0h vk=%0h qj=%0d qk=%0d cdb=%0b/%0d/%0h gr=%0b -> req=%0b tag=%0d data=%0h",
                 cyc, iv, op, vj, vk, qj, qk, cv, ct, cd, gr, bus.cdb_req, bus.cdb_req_tag, bus.cdb_req_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0, 0);
    endtask

    task automatic issue(input bit op, input logic [15:0] vj, vk, input int qj, qk);
        step(1, op, vj, vk, qj, qk, 0, 0, 16'h0, 0);
    endtask

    task automatic grant();
        step(0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0, 1);
    endtask

    // Grant whatever is on offer and broadcast tags that entries are waiting on.
    task automatic drain();
        int budget;
        budget = 0;
        while (m_count() != 0 && budget < 300) begin
            int t;
            t = 0;
            if (m_req()) t = m_fly + 1;
            else for (int i = NUM_RS - 1; i >= 0; i--)
                if (m_busy[i] && (m_qj[i] != 0 || m_qk[i] != 0)) t = (m_qj[i] != 0) ? m_qj[i] : m_qk[i];
            step(0, 0, 16'h0, 16'h0, 0, 0, t != 0, t, m_req() ? m_result(m_fly) : 16'($urandom), 1);
            budget++;
        end
        check_eq("drain_empty", 32'(m_count()), 32'd0);
        idle(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst = 1'b1;
        bus.issue_valid = 0; bus.issue_op = 0; bus.issue_vj = '0; bus.issue_vk = '0;
        bus.issue_qj = '0; bus.issue_qk = '0; bus.cdb_valid = 0; bus.cdb_tag = '0;
        bus.cdb_data = '0; bus.cdb_grant = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        check_eq("rst_issue_tag", 32'(bus.issue_tag), 32'd1);
        check_eq("rst_cdb_req", 32'(bus.cdb_req), 32'd0);
        check_eq("rst_req_tag", 32'(bus.cdb_req_tag), 32'd0);
        check_eq("rst_req_data", 32'(bus.cdb_req_data), 32'd0);
        check_eq("rst_fu_a", 32'(bus.fu_a), 32'd0);
        check_eq("rst_fu_b", 32'(bus.fu_b), 32'd0);
        check_eq("rst_fu_op", 32'(bus.fu_op), 32'd0);
        rst = 1'b0;

        // 5 + 7: result on offer three edges after the issue edge.
        issue(OP_ADD, 16'd5, 16'd7, 0, 0);
        idle(2);
        check_eq("add_not_yet", 32'(bus.cdb_req), 32'd0);
        idle(1);
        check_eq("add_req", 32'(bus.cdb_req), 32'd1);
        check_eq("add_tag", 32'(bus.cdb_req_tag), 32'd1);
        check_eq("add_data", 32'(bus.cdb_req_data), 32'd12);
        grant();
        check_eq("add_freed_ready", 32'(bus.issue_ready), 32'd1);
        check_eq("add_freed_tag", 32'(bus.issue_tag), 32'd1);
        idle(1);

        // 3 - 5 wraps.
        issue(OP_SUB, 16'd3, 16'd5, 0, 0);
        idle(3);
        check_eq("sub_wrap", 32'(bus.cdb_req_data), 32'hFFFE);
        grant();
        idle(1);

        // Pending qj woken by CDB tag 2.
        issue(OP_ADD, 16'hDEAD, 16'd1, 2, 0);
        idle(1);
        step(0, 0, 16'h0, 16'h0, 0, 0, 1, 2, 16'd100, 0);
        idle(3);
        check_eq("wake_req", 32'(bus.cdb_req), 32'd1);
        check_eq("wake_data", 32'(bus.cdb_req_data), 32'd101);
        grant();
        idle(1);

        // Fill all entries, stall the grant, then free entry 1.
        issue(OP_ADD, 16'd1, 16'd1, 0, 0);
        issue(OP_ADD, 16'd2, 16'd2, 0, 0);
        issue(OP_ADD, 16'd3, 16'd3, 0, 0);
        check_eq("full_not_ready", 32'(bus.issue_ready), 32'd0);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_req", 32'(bus.cdb_req), 32'd1);
            check_eq("stall_data", 32'(bus.cdb_req_data), 32'd2);
            idle(1);
        end
        grant();
        check_eq("full_freed_ready", 32'(bus.issue_ready), 32'd1);
        check_eq("full_freed_tag", 32'(bus.issue_tag), 32'd1);
        drain();

        // Same-cycle bypass of tag 3 at issue.
        step(1, OP_ADD, 16'hBEEF, 16'd4, 3, 0, 1, 3, 16'd9, 0);
        idle(3);
        check_eq("bypass_req", 32'(bus.cdb_req), 32'd1);
        check_eq("bypass_data", 32'(bus.cdb_req_data), 32'd13);
        drain();

        // Reset while the unit is executing.
        issue(OP_ADD, 16'd20, 16'd22, 0, 0);
        idle(1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_req", 32'(bus.cdb_req), 32'd0);
        check_eq("mid_rst_ready", 32'(bus.issue_ready), 32'd1);
        check_eq("mid_rst_fu_a", 32'(bus.fu_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(6);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            bit          iv, op, cv, gr;
            int          qj, qk, ct;
            logic [15:0] cd;
            iv = ($urandom % 3) == 0;
            op = 1'($urandom);
            qj = (($urandom % 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            qk = (($urandom % 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            gr = 1'($urandom);
            if (gr && m_req() && ($urandom % 2) == 0) begin
                cv = 1; ct = m_fly + 1; cd = m_result(m_fly);
            end else begin
                cv = ($urandom % 4) == 0; ct = int'($urandom_range(0, 3)); cd = 16'($urandom);
            end
            step(iv, op, 16'($urandom), 16'($urandom), qj, qk, cv, ct, cd, gr);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
